memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single external memory port between instruction fetch (imem) and the decode stage's load/store port (dmem). It holds one transaction in flight on the shared port and buffers one pending request per requester, so a single-cycle request pulse is never lost. Responses are routed back to the issuing requester. Data requests have priority over instruction requests. The block sits between the fetch and decode stages and the memory/bus interface in the core top level.

## Interface
Parameters: none. Widths come from the shared `mem_in_type`/`mem_out_type`: addr 32, wdata 32, wstrb 4, rdata 32.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- imem_in  in  mem_in_type  fetch request; `mem_valid` is a one-cycle pulse, `mem_instr`=1
- imem_out  out  mem_out_type  fetch response: `mem_ready` pulse plus `mem_rdata`
- dmem_in  in  mem_in_type  load/store request from decode; one-cycle pulse; `mem_wstrb`=0 means load
- dmem_out  out  mem_out_type  load/store response
- mem_in  out  mem_in_type  shared-port request; one-cycle `mem_valid` pulse per transaction
- mem_out  in  mem_out_type  shared-port response; `mem_ready` pulse in any cycle after issue

## Operation
- State machine states:
  - IDLE: no transaction outstanding.
  - IBUSY: an instruction transaction is outstanding.
  - DBUSY: a data transaction is outstanding.
- Two pending slots, `ipend` and `dpend`. Each holds valid, instr, addr, wdata, wstrb.
- IDLE, requests pass through combinationally in the same cycle, in this priority order:
  - dpend valid: issue dpend, clear dpend, go to DBUSY.
  - else ipend valid: issue ipend, clear ipend, go to IBUSY.
  - else dmem_in.mem_valid: issue dmem_in, go to DBUSY. If imem_in.mem_valid is also high, latch it into ipend.
  - else imem_in.mem_valid: issue imem_in, go to IBUSY.
- IBUSY/DBUSY:
  - Any incoming request pulse is latched into its own slot.
  - mem_out.mem_ready is forwarded combinationally to the owner's `mem_ready`; mem_out.mem_rdata goes to the owner's `mem_rdata`.
  - The other requester sees `mem_ready`=0.
  - On mem_ready, go to IDLE. Nothing is issued in that cycle; pending slots are served from the next cycle.
- mem_out.mem_ready while IDLE is a stale response. It is dropped, and neither requester sees `mem_ready`.
- A request arriving while its own slot is already valid is a protocol violation. Requesters never do this. The RTL carries an assertion; its behaviour is otherwise undefined.
- The non-owner `mem_rdata` output is driven 0.

## Timing
- Reset values:
  - state IDLE, both slots invalid.
  - mem_in.mem_valid=0; imem_out/dmem_out mem_ready=0 and mem_rdata=0 whenever no response is routed.
- Reset mid-transaction: state returns to IDLE and both slots clear. A response arriving afterwards is dropped as stale.
- Added latency on an idle port: 0 cycles (combinational pass-through).
- A request buffered behind a transaction completing in cycle T is issued in cycle T+1.
- Back-to-back throughput on the shared port: one transaction every 2 cycles minimum (issue, then ready in the next cycle, then a 1-cycle gap).
- Simultaneous new dmem pulse and a valid ipend in IDLE: ipend wins, because pending is served before new requests, and the dmem pulse is latched.
- Simultaneous mem_ready and a new pulse from the owner: the response is routed, the pulse is latched, and it is issued next cycle.

## Structure
- Package `constants`: arbiter state encoding (`arb_idle`, `arb_ibusy`, `arb_dbusy`).
- Package `wires`: `mem_arbiter_reg_type` (state, ipend, dpend fields) and the `init_mem_arbiter_reg` constant.
- One natural sub-module: `mem_request_slot`, a single-entry request buffer with set/clear. It is instantiated twice.
- The top module follows the two-process style: a combinational `v`/`rin` process plus a registered `r`.

## Test plan
- Single load: dmem pulse addr=0x100, wstrb=0 in IDLE.
  - Required: mem_in.mem_valid=1 with addr 0x100 in the same cycle.
  - Return ready with rdata=0xDEADBEEF 3 cycles later. Required: dmem_out.mem_ready=1, rdata=0xDEADBEEF; imem_out.mem_ready=0.
- Simultaneous requests: imem 0x0 and dmem store 0x200 (wdata 0x12345678, wstrb 0xF) together.
  - Required: store issued first.
  - After its ready, imem 0x0 is issued in the next cycle and its response reaches imem_out only.
- Buffering: while DBUSY, a fetch pulse at addr 0x40.
  - Required: no shared-port valid until the cycle after ready; then addr 0x40 is issued, mem_instr=1.
- Pending priority: ipend holds 0x80 and, in the IDLE cycle it would issue, a new dmem pulse 0x300 arrives.
  - Required: 0x80 issued first, then 0x300.
- Reset mid-operation: rst=0 during IBUSY, then the late mem_ready arrives.
  - Required: both requesters' mem_ready=0, slots empty, next request passes through immediately.
- Owner re-request on completion: dmem pulse 0x104 in the ready cycle of 0x100.
  - Required: 0x104 issued exactly one cycle later.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Arbiter state encoding and the memory-port / arbiter register types
// shared by the fetch, decode and memory-interface blocks.
package constants;

   typedef enum logic [1:0] {
      arb_idle,
      arb_ibusy,
      arb_dbusy
   } arb_state_t;

endpackage

package wires;

   import constants::*;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;

   // A pending slot reuses the request layout; mem_valid marks it occupied.
   typedef struct packed {
      arb_state_t state;
      mem_in_type ipend;
      mem_in_type dpend;
   } mem_arbiter_reg_type;

   localparam mem_arbiter_reg_type init_mem_arbiter_reg = '{
      state: arb_idle,
      ipend: '0,
      dpend: '0
   };

endpackage

// File: rtl/memory_arbiter_slot.sv
// Single-entry request buffer: next-value logic for one pending slot.
// Set captures the incoming request and wins over clear.
module mem_request_slot
   import wires::*;
(
   input  mem_in_type slot_q_i,
   input  logic       set_i,
   input  logic       clr_i,
   input  mem_in_type req_i,
   output mem_in_type slot_d_o
);

   always_comb begin
      slot_d_o = slot_q_i;
      if (clr_i) begin
         slot_d_o.mem_valid = 1'b0;
      end
      if (set_i) begin
         slot_d_o           = req_i;
         slot_d_o.mem_valid = 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the external memory port between fetch (imem) and load/store (dmem):
// one transaction in flight, one buffered request per requester, dmem first.
module memory_arbiter
   import constants::*;
   import wires::*;
(
   input  logic        clk,
   input  logic        rst,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  mem_in,
   input  mem_out_type mem_out
);

   mem_arbiter_reg_type r_q;
   mem_arbiter_reg_type rin_d;
   arb_state_t          state_d;
   mem_in_type          ipend_d;
   mem_in_type          dpend_d;
   logic                iset;
   logic                iclr;
   logic                dset;
   logic                dclr;

   mem_request_slot u_islot (
      .slot_q_i (r_q.ipend),
      .set_i    (iset),
      .clr_i    (iclr),
      .req_i    (imem_in),
      .slot_d_o (ipend_d)
   );

   mem_request_slot u_dslot (
      .slot_q_i (r_q.dpend),
      .set_i    (dset),
      .clr_i    (dclr),
      .req_i    (dmem_in),
      .slot_d_o (dpend_d)
   );

   // Outputs are held quiet while rst is asserted so nothing leaks out mid-reset.
   always_comb begin
      state_d  = r_q.state;
      mem_in   = '0;
      imem_out = '0;
      dmem_out = '0;
      iset     = 1'b0;
      iclr     = 1'b0;
      dset     = 1'b0;
      dclr     = 1'b0;
      if (rst) begin
         unique case (r_q.state)
            arb_idle: begin
               if (r_q.dpend.mem_valid) begin
                  mem_in  = r_q.dpend;
                  dclr    = 1'b1;
                  iset    = imem_in.mem_valid;
                  state_d = arb_dbusy;
               end else if (r_q.ipend.mem_valid) begin
                  mem_in  = r_q.ipend;
                  iclr    = 1'b1;
                  dset    = dmem_in.mem_valid;
                  state_d = arb_ibusy;
               end else if (dmem_in.mem_valid) begin
                  mem_in  = dmem_in;
                  iset    = imem_in.mem_valid;
                  state_d = arb_dbusy;
               end else if (imem_in.mem_valid) begin
                  mem_in  = imem_in;
                  state_d = arb_ibusy;
               end
            end
            arb_ibusy: begin
               iset = imem_in.mem_valid;
               dset = dmem_in.mem_valid;
               if (mem_out.mem_ready) begin
                  imem_out = mem_out;
                  state_d  = arb_idle;
               end
            end
            arb_dbusy: begin
               iset = imem_in.mem_valid;
               dset = dmem_in.mem_valid;
               if (mem_out.mem_ready) begin
                  dmem_out = mem_out;
                  state_d  = arb_idle;
               end
            end
            default: state_d = arb_idle;
         endcase
      end
   end

   assign rin_d = '{state: state_d, ipend: ipend_d, dpend: dpend_d};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= init_mem_arbiter_reg;
      end else begin
         r_q <= rin_d;
      end
   end

   a_ipend_overrun: assert property (@(posedge clk) disable iff (!rst)
      !(imem_in.mem_valid && r_q.ipend.mem_valid));

   a_dpend_overrun: assert property (@(posedge clk) disable iff (!rst)
      !(dmem_in.mem_valid && r_q.dpend.mem_valid));

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected issues and responses are
// queued as stimulus is driven and retired as the shared port/owners react.
module tb_memory_arbiter;
   import wires::*;

   logic        clk = 1'b0;
   logic        rst;
   mem_in_type  imem_in;
   mem_in_type  dmem_in;
   mem_in_type  mem_in;
   mem_out_type imem_out;
   mem_out_type dmem_out;
   mem_out_type mem_out;

   memory_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .imem_in  (imem_in),
      .imem_out (imem_out),
      .dmem_in  (dmem_in),
      .dmem_out (dmem_out),
      .mem_in   (mem_in),
      .mem_out  (mem_out)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   mem_in_type  exp_issue[$];
   logic [31:0] exp_iresp[$];
   logic [31:0] exp_dresp[$];

   logic        issued_now;
   logic [31:0] issued_addr;
   logic        irdy_now;
   logic        drdy_now;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Retire whatever the DUT presents this cycle against the scoreboard.
   task automatic observe();
      mem_in_type  e;
      logic [31:0] r;
      issued_now  = mem_in.mem_valid;
      issued_addr = mem_in.mem_addr;
      irdy_now    = imem_out.mem_ready;
      drdy_now    = dmem_out.mem_ready;
      if (mem_in.mem_valid) begin
         if (exp_issue.size() == 0) begin
            check_eq("issue_unexpected", 32'(mem_in.mem_valid), 32'd0);
         end else begin
            e = exp_issue.pop_front();
            check_eq("issue_addr",  mem_in.mem_addr,        e.mem_addr);
            check_eq("issue_wdata", mem_in.mem_wdata,       e.mem_wdata);
            check_eq("issue_wstrb", 32'(mem_in.mem_wstrb), 32'(e.mem_wstrb));
            check_eq("issue_instr", 32'(mem_in.mem_instr), 32'(e.mem_instr));
         end
      end
      if (imem_out.mem_ready) begin
         if (exp_iresp.size() == 0) begin
            check_eq("imem_ready_unexpected", 32'(imem_out.mem_ready), 32'd0);
         end else begin
            r = exp_iresp.pop_front();
            check_eq("imem_rdata", imem_out.mem_rdata, r);
         end
      end else begin
         check_eq("imem_rdata_quiet", imem_out.mem_rdata, 32'd0);
      end
      if (dmem_out.mem_ready) begin
         if (exp_dresp.size() == 0) begin
            check_eq("dmem_ready_unexpected", 32'(dmem_out.mem_ready), 32'd0);
         end else begin
            r = exp_dresp.pop_front();
            check_eq("dmem_rdata", dmem_out.mem_rdata, r);
         end
      end else begin
         check_eq("dmem_rdata_quiet", dmem_out.mem_rdata, 32'd0);
      end
   endtask

   // Observe at the falling edge, then release the one-cycle pulses after the rising edge.
   task automatic tick();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      imem_in = '0;
      dmem_in = '0;
      mem_out = '0;
   endtask

   task automatic req_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input bit will_issue);
      dmem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: a, mem_wdata: wd, mem_wstrb: ws};
      if (will_issue) exp_issue.push_back(dmem_in);
   endtask

   task automatic req_i(input logic [31:0] a, input bit will_issue);
      imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: a, mem_wdata: 32'd0, mem_wstrb: 4'd0};
      if (will_issue) exp_issue.push_back(imem_in);
   endtask

   task automatic resp(input logic [31:0] rd, input bit to_d);
      mem_out = '{mem_ready: 1'b1, mem_rdata: rd};
      if (to_d) exp_dresp.push_back(rd);
      else      exp_iresp.push_back(rd);
   endtask

   initial begin
      imem_in = '0;
      dmem_in = '0;
      mem_out = '0;
      rst     = 1'b0;
      @(posedge clk);
      #1;
      tick();
      check_eq("rst_mem_valid",   32'(mem_in.mem_valid),   32'd0);
      check_eq("rst_imem_ready",  32'(imem_out.mem_ready), 32'd0);
      check_eq("rst_dmem_ready",  32'(dmem_out.mem_ready), 32'd0);
      rst = 1'b1;
      tick();

      // Single load with a 3-cycle response.
      req_d(32'h100, 32'd0, 4'h0, 1'b1);
      tick();
      check_eq("t1_passthru", 32'(issued_now), 32'd1);
      check_eq("t1_addr",     issued_addr,     32'h100);
      tick();
      tick();
      resp(32'hDEADBEEF, 1'b1);
      tick();
      check_eq("t1_dready", 32'(drdy_now), 32'd1);
      check_eq("t1_iready", 32'(irdy_now), 32'd0);
      tick();

      // Simultaneous store and fetch: store first, fetch right after the gap.
      req_d(32'h200, 32'h12345678, 4'hF, 1'b1);
      req_i(32'h0, 1'b1);
      tick();
      check_eq("t2_store_first", issued_addr, 32'h200);
      resp(32'hA5A50001, 1'b1);
      tick();
      check_eq("t2_ready_gap", 32'(issued_now), 32'd0);
      tick();
      check_eq("t2_fetch_issue", 32'(issued_now), 32'd1);
      check_eq("t2_fetch_addr",  issued_addr,     32'h0);
      resp(32'hCAFEF00D, 1'b0);
      tick();
      check_eq("t2_iready", 32'(irdy_now), 32'd1);
      check_eq("t2_dready", 32'(drdy_now), 32'd0);
      tick();

      // Fetch buffered while DBUSY.
      req_d(32'h500, 32'd0, 4'h0, 1'b1);
      tick();
      req_i(32'h40, 1'b1);
      tick();
      check_eq("t3_hold_a", 32'(issued_now), 32'd0);
      tick();
      check_eq("t3_hold_b", 32'(issued_now), 32'd0);
      resp(32'h11111111, 1'b1);
      tick();
      check_eq("t3_hold_ready", 32'(issued_now), 32'd0);
      tick();
      check_eq("t3_issue",      32'(issued_now), 32'd1);
      check_eq("t3_issue_addr", issued_addr,     32'h40);
      resp(32'h40404040, 1'b0);
      tick();
      tick();

      // Pending fetch beats a fresh data pulse in the same IDLE cycle.
      req_d(32'h600, 32'd0, 4'h0, 1'b1);
      tick();
      req_i(32'h80, 1'b1);
      tick();
      resp(32'h00000066, 1'b1);
      tick();
      req_d(32'h300, 32'h0000BEEF, 4'h3, 1'b1);
      tick();
      check_eq("t4_ipend_first", issued_addr, 32'h80);
      resp(32'h80808080, 1'b0);
      tick();
      check_eq("t4_ready_gap", 32'(issued_now), 32'd0);
      tick();
      check_eq("t4_dpend_next", issued_addr, 32'h300);
      resp(32'h00000000, 1'b1);
      tick();
      tick();

      // Reset during IBUSY with a buffered data request, then a stale ready.
      req_i(32'h900, 1'b1);
      tick();
      req_d(32'hA00, 32'd0, 4'h0, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hBAD0BAD0};
      tick();
      check_eq("t5_stale_iready", 32'(irdy_now),   32'd0);
      check_eq("t5_stale_dready", 32'(drdy_now),   32'd0);
      check_eq("t5_stale_issue",  32'(issued_now), 32'd0);
      tick();
      check_eq("t5_dpend_cleared", 32'(issued_now), 32'd0);
      req_d(32'h700, 32'd0, 4'h0, 1'b1);
      tick();
      check_eq("t5_passthru", 32'(issued_now), 32'd1);
      check_eq("t5_addr",     issued_addr,     32'h700);
      resp(32'h77777777, 1'b1);
      tick();
      tick();

      // Owner re-requests in its own ready cycle.
      req_d(32'h100, 32'd0, 4'h0, 1'b1);
      tick();
      resp(32'h01000100, 1'b1);
      req_d(32'h104, 32'd0, 4'h0, 1'b1);
      tick();
      check_eq("t6_ready",    32'(drdy_now),   32'd1);
      check_eq("t6_no_issue", 32'(issued_now), 32'd0);
      tick();
      check_eq("t6_next_issue", 32'(issued_now), 32'd1);
      check_eq("t6_next_addr",  issued_addr,     32'h104);
      resp(32'h01040104, 1'b1);
      tick();
      tick();

      check_eq("issue_q_left", 32'(exp_issue.size()), 32'd0);
      check_eq("iresp_q_left", 32'(exp_iresp.size()), 32'd0);
      check_eq("dresp_q_left", 32'(exp_dresp.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
